// File: rtl/tlu_pkg.sv
// Shared definitions for the TLU trigger-number transmitter.
// State encoding, width limits and counter widths.
package tlu_pkg;

  localparam int TLU_MAX_DATA_WIDTH = 31;
  localparam int MISSED_W = 8;

  localparam logic [1:0] ST_IDLE_E     = 2'd0;
  localparam logic [1:0] ST_TRIGGER_E  = 2'd1;
  localparam logic [1:0] ST_WAIT_CLK_E = 2'd2;
  localparam logic [1:0] ST_DONE_E     = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE     = ST_IDLE_E,
    ST_TRIGGER  = ST_TRIGGER_E,
    ST_WAIT_CLK = ST_WAIT_CLK_E,
    ST_DONE     = ST_DONE_E
  } tlu_state_t;

endpackage

// File: rtl/tlu_sync_edge.sv
// Multi-flop synchronizer with registered rising/falling edge pulses.
// Edge pulses are aligned with the first cycle of the new synced level.
module tlu_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic CLK,
  input  logic RESET,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_rise;
  logic              r_fall;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_sync <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_rise <= r_sync[STAGES-2] & ~r_sync[STAGES-1];
      r_fall <= ~r_sync[STAGES-2] & r_sync[STAGES-1];
    end
  end

  assign o_q    = r_sync[STAGES-1];
  assign o_rise = r_rise;
  assign o_fall = r_fall;

endmodule

// File: rtl/tlu_trigger_number_tx.sv
// TLU-side trigger/busy/clock handshake: trigger, then serial trigger number.
// Optional busy-handshake timeout enabled by defining TLU_TX_TIMEOUT_EN.
module tlu_trigger_number_tx
  import tlu_pkg::*;
#(
  parameter int DATA_WIDTH  = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  TRIGGER_IN,
  input  logic                  MSB_FIRST,
  input  logic [15:0]           TIMEOUT_CYCLES,
  input  logic                  NUMBER_LOAD,
  input  logic [DATA_WIDTH-1:0] NUMBER_LOAD_VALUE,
  input  logic                  TLU_BUSY,
  input  logic                  TLU_CLOCK,
  output logic                  TLU_TRIGGER,
  output logic [DATA_WIDTH-1:0] TRIGGER_NUMBER,
  output logic                  TX_ACTIVE,
  output logic [MISSED_W-1:0]   MISSED_TRIGGERS,
  output logic                  TX_ERROR,
  output logic                  TX_TIMEOUT
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] BITS = CW'(DATA_WIDTH);

  tlu_state_t            r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_sr, w_sr_nxt;
  logic [DATA_WIDTH-1:0] r_num, w_num_nxt;
  logic [DATA_WIDTH-1:0] w_load_val, w_rev;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_trig, w_trig_nxt;
  logic [MISSED_W-1:0]   r_missed, w_missed_nxt;
  logic                  w_busy_s, w_busy_rise, w_busy_fall;
  logic                  w_clk_s, w_clk_rise, w_clk_fall;
  logic                  w_unused;

  tlu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_busy (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_d    (TLU_BUSY),
    .o_q    (w_busy_s),
    .o_rise (w_busy_rise),
    .o_fall (w_busy_fall)
  );

  tlu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_clk (
    .CLK    (CLK),
    .RESET  (RESET),
    .i_d    (TLU_CLOCK),
    .o_q    (w_clk_s),
    .o_rise (w_clk_rise),
    .o_fall (w_clk_fall)
  );

`ifdef TLU_TX_TIMEOUT_EN
  logic [15:0] r_tmo_cnt, w_tmo_cnt_nxt;
  logic        r_tmo, w_tmo_nxt;
  logic        w_tmo_hit;

  assign w_tmo_hit = (TIMEOUT_CYCLES != 16'd0) &&
                     (r_tmo_cnt == TIMEOUT_CYCLES - 16'd1);
  assign w_tmo_cnt_nxt = (r_state == ST_TRIGGER) ?
                         r_tmo_cnt + 16'd1 : 16'd0;
  assign w_unused = ^{w_busy_rise, w_busy_fall,
                      w_clk_s, w_clk_fall};
`else
  assign w_unused = ^{w_busy_rise, w_busy_fall,
                      w_clk_s, w_clk_fall, TIMEOUT_CYCLES};
`endif

  always_comb begin
    w_rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++)
      w_rev[i] = w_load_val[DATA_WIDTH-1-i];
  end

  assign w_load_val = NUMBER_LOAD ? NUMBER_LOAD_VALUE : r_num;

  always_comb begin
    w_state_nxt  = r_state;
    w_sr_nxt     = r_sr;
    w_num_nxt    = r_num;
    w_cnt_nxt    = r_cnt;
    w_trig_nxt   = r_trig;
    w_missed_nxt = r_missed;
`ifdef TLU_TX_TIMEOUT_EN
    w_tmo_nxt    = 1'b0;
`endif
    // Requests arriving mid-transfer are dropped, only counted.
    if (TRIGGER_IN && ENABLE && r_state != ST_IDLE &&
        r_missed != {MISSED_W{1'b1}})
      w_missed_nxt = r_missed + 1'b1;
    unique case (r_state)
      ST_IDLE: begin
        w_trig_nxt = 1'b0;
        w_num_nxt  = w_load_val;
        if (TRIGGER_IN && ENABLE) begin
          w_sr_nxt    = MSB_FIRST ? w_load_val : w_rev;
          w_cnt_nxt   = '0;
          w_trig_nxt  = 1'b1;
          w_state_nxt = ST_TRIGGER;
        end
      end
      ST_TRIGGER: begin
        if (w_busy_s) begin
          w_trig_nxt  = 1'b0;
          w_state_nxt = ST_WAIT_CLK;
        end
`ifdef TLU_TX_TIMEOUT_EN
        else if (w_tmo_hit) begin
          w_trig_nxt  = 1'b0;
          w_num_nxt   = r_num + 1'b1;
          w_tmo_nxt   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
`endif
      end
      ST_WAIT_CLK: begin
        if (w_clk_rise) begin
          if (r_cnt < BITS) begin
            w_trig_nxt = r_sr[DATA_WIDTH-1];
            w_sr_nxt   = r_sr << 1;
            w_cnt_nxt  = r_cnt + 1'b1;
          end else begin
            w_trig_nxt = 1'b0;
          end
        end
        if (!w_busy_s) begin
          w_trig_nxt  = 1'b0;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_trig_nxt  = 1'b0;
        w_num_nxt   = r_num + 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state  <= ST_IDLE;
      r_sr     <= '0;
      r_num    <= '0;
      r_cnt    <= '0;
      r_trig   <= 1'b0;
      r_missed <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sr     <= w_sr_nxt;
      r_num    <= w_num_nxt;
      r_cnt    <= w_cnt_nxt;
      r_trig   <= w_trig_nxt;
      r_missed <= w_missed_nxt;
    end
  end

`ifdef TLU_TX_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_tmo_cnt <= '0;
      r_tmo     <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_cnt_nxt;
      r_tmo     <= w_tmo_nxt;
    end
  end
  assign TX_TIMEOUT = r_tmo;
`else
  assign TX_TIMEOUT = 1'b0;
`endif

  assign TLU_TRIGGER     = r_trig;
  assign TRIGGER_NUMBER  = r_num;
  assign TX_ACTIVE       = (r_state != ST_IDLE);
  assign MISSED_TRIGGERS = r_missed;
  assign TX_ERROR        = (r_state == ST_DONE) && (r_cnt < BITS);

endmodule

// File: tb/tb_tlu_trigger_number_tx.sv
// Self-checking bench: directed and randomized transfers against a DUT model.
module tb_tlu_trigger_number_tx;

  localparam int DW = 15;
  localparam int SS = 2;
  localparam logic [DW-1:0] MASK = {DW{1'b1}};

  logic          CLK = 1'b0;
  logic          RESET, ENABLE, TRIGGER_IN, MSB_FIRST, NUMBER_LOAD;
  logic          TLU_BUSY, TLU_CLOCK;
  logic [15:0]   TIMEOUT_CYCLES;
  logic [DW-1:0] NUMBER_LOAD_VALUE;
  logic          TLU_TRIGGER, TX_ACTIVE, TX_ERROR, TX_TIMEOUT;
  logic [DW-1:0] TRIGGER_NUMBER;
  logic [7:0]    MISSED_TRIGGERS;

  tlu_trigger_number_tx #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .ENABLE            (ENABLE),
    .TRIGGER_IN        (TRIGGER_IN),
    .MSB_FIRST         (MSB_FIRST),
    .TIMEOUT_CYCLES    (TIMEOUT_CYCLES),
    .NUMBER_LOAD       (NUMBER_LOAD),
    .NUMBER_LOAD_VALUE (NUMBER_LOAD_VALUE),
    .TLU_BUSY          (TLU_BUSY),
    .TLU_CLOCK         (TLU_CLOCK),
    .TLU_TRIGGER       (TLU_TRIGGER),
    .TRIGGER_NUMBER    (TRIGGER_NUMBER),
    .TX_ACTIVE         (TX_ACTIVE),
    .MISSED_TRIGGERS   (MISSED_TRIGGERS),
    .TX_ERROR          (TX_ERROR),
    .TX_TIMEOUT        (TX_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;
  int mdl_missed = 0;

  int   n_err = 0, n_tmo = 0, n_start = 0;
  logic prev_act = 1'b0;

  always @(negedge CLK) begin
    if (TX_ERROR) n_err <= n_err + 1;
    if (TX_TIMEOUT) n_tmo <= n_tmo + 1;
    if (TX_ACTIVE && !prev_act) n_start <= n_start + 1;
    prev_act <= TX_ACTIVE;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_trig();
    TRIGGER_IN = 1'b1;
    cyc(1);
    TRIGGER_IN = 1'b0;
  endtask

  task automatic load(input logic [DW-1:0] v);
    NUMBER_LOAD = 1'b1;
    NUMBER_LOAD_VALUE = v;
    cyc(1);
    NUMBER_LOAD = 1'b0;
  endtask

  task automatic wait_trig(input logic v, input string tag);
    int t;
    for (t = 0; t < 20 && TLU_TRIGGER !== v; t++) cyc(1);
    chk(tag, {31'd0, TLU_TRIGGER}, {31'd0, v});
  endtask

  task automatic transfer(input logic [DW-1:0] num, input bit msb,
                          input int nclk, input int nmiss,
                          output logic [DW-1:0] got);
    logic [DW-1:0] exp;
    logic          b, eb;
    int            e0, s0, t;
    got = '0;
    exp = '0;
    e0 = n_err;
    s0 = n_start;
    chk("num_before", 32'(TRIGGER_NUMBER), 32'(num));
    MSB_FIRST = msb;
    pulse_trig();
    wait_trig(1'b1, "trig_hi");
    cyc(4);
    chk("trig_hold", {31'd0, TLU_TRIGGER}, 32'd1);
    TLU_BUSY = 1'b1;
    wait_trig(1'b0, "trig_lo");
    for (int m = 0; m < nmiss; m++) begin
      pulse_trig();
      cyc(1);
    end
    mdl_missed = (mdl_missed + nmiss > 255) ? 255 : mdl_missed + nmiss;
    for (int i = 0; i < nclk; i++) begin
      TLU_CLOCK = 1'b1;
      cyc(6);
      b = TLU_TRIGGER;
      TLU_CLOCK = 1'b0;
      cyc(6);
      if (i < DW) begin
        eb = msb ? num[DW-1-i] : num[i];
        got = {got[DW-2:0], b};
        exp = {exp[DW-2:0], eb};
      end else begin
        chk("extra_bit", {31'd0, b}, 32'd0);
      end
    end
    TLU_BUSY = 1'b0;
    for (t = 0; t < 20 && TX_ACTIVE !== 1'b0; t++) cyc(1);
    cyc(1);
    chk("idle", {31'd0, TX_ACTIVE}, 32'd0);
    chk("serial", 32'(got), 32'(exp));
    chk("num_after", 32'(TRIGGER_NUMBER), 32'((num + 1'b1) & MASK));
    chk("tx_error", 32'(n_err - e0), (nclk < DW) ? 32'd1 : 32'd0);
    chk("starts", 32'(n_start - s0), 32'd1);
    chk("missed", 32'(MISSED_TRIGGERS), 32'(mdl_missed));
  endtask

  initial begin
    logic [DW-1:0] got, num;
    int            nclk, t;
    RESET = 1'b1;
    ENABLE = 1'b1;
    TRIGGER_IN = 1'b0;
    MSB_FIRST = 1'b1;
    NUMBER_LOAD = 1'b0;
    NUMBER_LOAD_VALUE = '0;
    TLU_BUSY = 1'b0;
    TLU_CLOCK = 1'b0;
    TIMEOUT_CYCLES = 16'd0;
    cyc(3);
    chk("rst_trig", {31'd0, TLU_TRIGGER}, 32'd0);
    chk("rst_num", 32'(TRIGGER_NUMBER), 32'd0);
    chk("rst_act", {31'd0, TX_ACTIVE}, 32'd0);
    chk("rst_missed", 32'(MISSED_TRIGGERS), 32'd0);
    chk("rst_err", {31'd0, TX_ERROR}, 32'd0);
    RESET = 1'b0;
    cyc(3);

    load(15'h5A5A);
    transfer(15'h5A5A, 1'b1, DW, 0, got);
    chk("msb_pattern", 32'(got), 32'(15'b101101001011010));

    load(15'd1);
    transfer(15'd1, 1'b0, DW, 0, got);
    chk("lsb_pattern", 32'(got), 32'(15'h4000));

    transfer(15'd2, 1'b1, DW, 3, got);
    transfer(15'd3, 1'b1, 8, 0, got);

    load(15'h7FFF);
    transfer(15'h7FFF, 1'b1, DW, 0, got);
    chk("wrap", 32'(TRIGGER_NUMBER), 32'd0);

    ENABLE = 1'b0;
    pulse_trig();
    cyc(5);
    chk("disabled", {31'd0, TX_ACTIVE}, 32'd0);
    ENABLE = 1'b1;

    load(15'h1234);
    pulse_trig();
    wait_trig(1'b1, "rst_tr_hi");
    TLU_BUSY = 1'b1;
    wait_trig(1'b0, "rst_tr_lo");
    for (int i = 0; i < 4; i++) begin
      TLU_CLOCK = 1'b1;
      cyc(6);
      TLU_CLOCK = 1'b0;
      cyc(6);
    end
    pulse_trig();
    TLU_CLOCK = 1'b1;
    cyc(4);
    RESET = 1'b1;
    #1;
    chk("midrst_trig", {31'd0, TLU_TRIGGER}, 32'd0);
    chk("midrst_num", 32'(TRIGGER_NUMBER), 32'd0);
    chk("midrst_act", {31'd0, TX_ACTIVE}, 32'd0);
    chk("midrst_miss", 32'(MISSED_TRIGGERS), 32'd0);
    mdl_missed = 0;
    TLU_BUSY = 1'b0;
    TLU_CLOCK = 1'b0;
    cyc(2);
    RESET = 1'b0;
    cyc(4);
    transfer(15'd0, 1'b1, DW, 0, got);

    for (int k = 0; k < 12; k++) begin
      num = DW'($urandom);
      load(num);
      nclk = ($urandom_range(0, 3) == 0) ? $urandom_range(1, DW - 1)
                                         : DW + $urandom_range(0, 2);
      transfer(num, 1'($urandom), nclk, $urandom_range(0, 3), got);
    end

`ifdef TLU_TX_TIMEOUT_EN
    begin
      int m0;
      m0 = n_tmo;
      TIMEOUT_CYCLES = 16'd100;
      load(15'h0100);
      pulse_trig();
      for (t = 0; t < 98; t++) cyc(1);
      chk("tmo_early", 32'(n_tmo - m0), 32'd0);
      for (t = 0; t < 20 && TX_ACTIVE !== 1'b0; t++) cyc(1);
      cyc(2);
      chk("tmo_pulse", 32'(n_tmo - m0), 32'd1);
      chk("tmo_trig", {31'd0, TLU_TRIGGER}, 32'd0);
      chk("tmo_num", 32'(TRIGGER_NUMBER), 32'h0101);
      TIMEOUT_CYCLES = 16'd0;
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
